sa_autosa_pdp_rdma_reg_host: RTL and testbench

SA_AUTOSA_PDP_RDMA_REG_HOST -- requirements
Module: sa_autosa_pdp_rdma_reg_host

---
 rtl/sa_autosa_pdp_rdma_reg_host_pkg.sv | 26 ++
 rtl/sa_autosa_pdp_rdma_poll_timer.sv | 56 +++++
 rtl/sa_autosa_pdp_rdma_reg_host.sv | 138 +++++++++++++
 tb/tb_sa_autosa_pdp_rdma_reg_host.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_autosa_pdp_rdma_reg_host_pkg.sv
// Shared definitions for the PDP RDMA register host: FSM states, register
// offsets and bit positions of the pointer/status fields.
package sa_autosa_pdp_rdma_reg_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PTR,
    WR_PTR,
    POLL,
    RD_STAT,
    RESP
  } state_t;

  localparam logic [11:0] PTR_OFFSET    = 12'h004;
  localparam logic [11:0] STATUS_OFFSET = 12'h000;

  // Pointer register (PTR_OFFSET)
  localparam int PRODUCER_BIT = 0;
  localparam int CONSUMER_BIT = 16;

  // Status register (STATUS_OFFSET)
  localparam int STATUS0_LSB = 0;
  localparam int STATUS1_LSB = 16;
  localparam int STATUS_W    = 2;

endpackage

// File: rtl/sa_autosa_pdp_rdma_poll_timer.sv
// Poll pacing for the register host: strobes a pointer read on the first
// POLL cycle and every POLL_GAP+1 cycles after. With macro
// AUTOSA_PDP_RDMA_REG_HOST_TIMEOUT_EN defined it also flags POLL cycle
// TIMEOUT_CYCLES-1; otherwise the timeout flag is constant 0.
module sa_autosa_pdp_rdma_poll_timer #(
  parameter int POLL_GAP       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic poll_rd,
  output logic timeout
);

  // Reject configurations that cannot be counted.
  if (POLL_GAP < 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("sa_autosa_pdp_rdma_poll_timer: invalid POLL_GAP/TIMEOUT_CYCLES");
  end

  localparam int GAP_W = $clog2(POLL_GAP + 1) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP);

  logic [GAP_W-1:0] gap_cnt;

  // Gap counter: restarts whenever the host is not polling.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n)                gap_cnt <= '0;
    else if (!en)              gap_cnt <= '0;
    else if (gap_cnt == GAP_LAST) gap_cnt <= '0;
    else                       gap_cnt <= gap_cnt + 1'b1;
  end

  assign poll_rd = en && (gap_cnt == '0);

`ifdef AUTOSA_PDP_RDMA_REG_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // POLL cycle counter; saturates since the FSM leaves POLL at TO_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               to_cnt <= '0;
    else if (!en)             to_cnt <= '0;
    else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = en && (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/sa_autosa_pdp_rdma_reg_host.sv
// PDP RDMA register host: SUBMIT flips the producer bit and polls until the
// consumer bit echoes it, STATUS just reads the status register; both end in
// a registered response. Optional poll timeout under macro
// AUTOSA_PDP_RDMA_REG_HOST_TIMEOUT_EN.
module sa_autosa_pdp_rdma_reg_host
  import sa_autosa_pdp_rdma_reg_host_pkg::*;
#(
  parameter int POLL_GAP       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_status_0,
  output logic [1:0]  resp_status_1,
  output logic        resp_producer,
  output logic        resp_timeout
);

  state_t state, state_nxt;
  logic   prod_q;     // last captured, then last written, producer value
  logic   poll_rd;
  logic   poll_to;
  logic   match;

  // Bits of the slave read data this host never looks at.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{reg_rd_data[31:18], reg_rd_data[15:2]};

  // After WR_PTR, prod_q already holds the new producer value to wait for.
  assign match = poll_rd && (reg_rd_data[CONSUMER_BIT] == prod_q);

  sa_autosa_pdp_rdma_poll_timer #(
    .POLL_GAP       (POLL_GAP),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_poll_timer (
    .clk     (autosa_core_clk),
    .rst_n   (autosa_core_rstn),
    .en      (state == POLL),
    .poll_rd (poll_rd),
    .timeout (poll_to)
  );

  // State register.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) state <= IDLE;
    else                   state <= state_nxt;
  end

  // Next state and register bus / handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    state_nxt   = state;
    cmd_ready   = 1'b0;
    resp_valid  = 1'b0;
    reg_offset  = '0;
    reg_wr_en   = 1'b0;
    reg_wr_data = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_op ? RD_STAT : RD_PTR;
      end
      RD_PTR: begin
        reg_offset = PTR_OFFSET;
        state_nxt  = WR_PTR;
      end
      WR_PTR: begin
        reg_offset                = PTR_OFFSET;
        reg_wr_en                 = 1'b1;
        reg_wr_data[PRODUCER_BIT] = ~prod_q;
        state_nxt                 = POLL;
      end
      POLL: begin
        if (poll_rd) reg_offset = PTR_OFFSET;
        if (match || poll_to) state_nxt = RD_STAT;
      end
      RD_STAT: begin
        reg_offset = STATUS_OFFSET;
        state_nxt  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Producer tracking and response capture; fields hold until the next RD_STAT.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      prod_q        <= 1'b0;
      resp_status_0 <= '0;
      resp_status_1 <= '0;
      resp_producer <= 1'b0;
    end else begin
      case (state)
        RD_PTR: prod_q <= reg_rd_data[PRODUCER_BIT];
        WR_PTR: prod_q <= ~prod_q;
        RD_STAT: begin
          resp_status_0 <= reg_rd_data[STATUS0_LSB +: STATUS_W];
          resp_status_1 <= reg_rd_data[STATUS1_LSB +: STATUS_W];
          resp_producer <= prod_q;
        end
        default: ;
      endcase
    end
  end

`ifdef AUTOSA_PDP_RDMA_REG_HOST_TIMEOUT_EN
  logic timeout_q;

  // Timeout flag: cleared while idle, set when POLL gives up without a match.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      timeout_q    <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      if (state == IDLE)                         timeout_q <= 1'b0;
      else if (state == POLL && poll_to && !match) timeout_q <= 1'b1;
      if (state == RD_STAT) resp_timeout <= timeout_q;
    end
  end
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sa_autosa_pdp_rdma_reg_host.sv
// Self-checking bench for sa_autosa_pdp_rdma_reg_host with a behavioural
// register slave and a cycle-level reference of the expected bus traffic.
module tb_sa_autosa_pdp_rdma_reg_host;

  localparam int POLL_GAP       = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int PERIOD         = POLL_GAP + 1;
`ifdef AUTOSA_PDP_RDMA_REG_HOST_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_status_0;
  logic [1:0]  resp_status_1;
  logic        resp_producer;
  logic        resp_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_autosa_pdp_rdma_reg_host #(
    .POLL_GAP       (POLL_GAP),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .autosa_core_clk  (clk),
    .autosa_core_rstn (rstn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .reg_offset       (reg_offset),
    .reg_wr_data      (reg_wr_data),
    .reg_wr_en        (reg_wr_en),
    .reg_rd_data      (reg_rd_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_status_0    (resp_status_0),
    .resp_status_1    (resp_status_1),
    .resp_producer    (resp_producer),
    .resp_timeout     (resp_timeout)
  );

  // Free-running cycle number; constant between rising edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register slave: producer written at 0x004 is echoed into the consumer
  // echo_delay cycles after the write cycle (never if echo_delay < 0).
  logic       sl_prod = 1'b0;
  logic       sl_cons = 1'b0;
  logic       echo_val = 1'b0;
  int         echo_at = -1;
  int         echo_delay = -1;
  logic       cons_sync = 1'b0;
  logic [1:0] st0 = 2'd0;
  logic [1:0] st1 = 2'd0;

  always @(posedge clk) begin
    if (reg_wr_en && reg_offset == 12'h004) begin
      sl_prod  <= reg_wr_data[0];
      echo_val <= reg_wr_data[0];
      echo_at  <= (echo_delay >= 0) ? cyc + echo_delay : -1;
    end
    if (echo_at >= 0 && echo_at == cyc + 1) sl_cons <= echo_val;
    if (cons_sync) sl_cons <= sl_prod;
  end

  assign reg_rd_data = (reg_offset == 12'h004) ? {15'd0, sl_cons, 15'd0, sl_prod} :
                       (reg_offset == 12'h000) ? {14'd0, st1, 14'd0, st0} :
                                                 32'hDEAD_BEEF;

  // Bus monitor: logs writes and pointer reads with their cycle numbers.
  int          wr_count = 0;
  int          wr_cyc = -1;
  logic [31:0] wr_data_last = '0;
  int          rd_cycs[$];

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_count++;
      wr_cyc       = cyc;
      wr_data_last = reg_wr_data;
    end
    if (reg_offset == 12'h004 && !reg_wr_en) rd_cycs.push_back(cyc);
  end

  // Reference state: slave pointer bits and the host's last producer value.
  logic m_slave_prod = 1'b0;
  logic m_slave_cons = 1'b0;
  logic m_dut_prod   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // POLL index of the matching read, or -1 if the consumer never matches.
  function automatic int exp_match_idx(input bit already, input int d);
    for (int k = 0; k < 64; k++) begin
      int t;
      t = PERIOD * k;
      if (already || (d >= 0 && 1 + t >= d)) return t;
    end
    return -1;
  endfunction

  task automatic issue(input logic op, output int a);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    a         = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output int rc, output bit got);
    got = 1'b0;
    rc  = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        rc  = cyc;
      end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_dut_prod = 1'b0;
  endtask

  task automatic sync_slave();
    @(negedge clk);
    cons_sync = 1'b1;
    @(negedge clk);
    cons_sync = 1'b0;
    m_slave_cons = m_slave_prod;
  endtask

  task automatic do_status(input string tag);
    int a, rc, base_wr;
    bit got;
    base_wr = wr_count;
    issue(1'b1, a);
    wait_resp(20, rc, got);
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(rc - a), 32'd2);
    check({tag, "_status_0"}, 32'(resp_status_0), 32'(st0));
    check({tag, "_status_1"}, 32'(resp_status_1), 32'(st1));
    check({tag, "_producer"}, 32'(resp_producer), 32'(m_dut_prod));
    check({tag, "_timeout"}, 32'(resp_timeout), 32'd0);
    check({tag, "_no_write"}, 32'(wr_count - base_wr), 32'd0);
    if (got) handshake();
    else pulse_reset();
  endtask

  task automatic do_submit(input int d, input string tag);
    int a, rc, base_wr, base_rd, idx, last_idx, n_exp, n_got, exp_rc;
    bit got, to_exp;
    logic new_p;
    new_p   = ~m_slave_prod;
    base_wr = wr_count;
    base_rd = rd_cycs.size();
    echo_delay = d;
    idx     = exp_match_idx(m_slave_cons == new_p, d);
    to_exp  = TIMEOUT_EN && (idx < 0 || idx > TIMEOUT_CYCLES - 1);
    last_idx = to_exp ? ((TIMEOUT_CYCLES - 1) / PERIOD) * PERIOD : idx;
    issue(1'b0, a);
    // RD_PTR at a+1, WR_PTR at a+2, POLL index i at a+3+i.
    exp_rc = to_exp ? a + 2 + TIMEOUT_CYCLES + 2 : a + 5 + idx;
    wait_resp(exp_rc - a + 10, rc, got);
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_resp_cycle"}, 32'(rc - a), 32'(exp_rc - a));
    check({tag, "_write_count"}, 32'(wr_count - base_wr), 32'd1);
    check({tag, "_write_cycle"}, 32'(wr_cyc - a), 32'd2);
    check({tag, "_write_data"}, wr_data_last, {31'd0, new_p});
    check({tag, "_producer"}, 32'(resp_producer), 32'(new_p));
    check({tag, "_timeout"}, 32'(resp_timeout), 32'(to_exp));
    check({tag, "_status_0"}, 32'(resp_status_0), 32'(st0));
    check({tag, "_status_1"}, 32'(resp_status_1), 32'(st1));
    n_exp = 2 + last_idx / PERIOD;
    n_got = rd_cycs.size() - base_rd;
    check({tag, "_ptr_reads"}, 32'(n_got), 32'(n_exp));
    for (int j = 0; j < n_exp && j < n_got; j++) begin
      int exp_c;
      exp_c = (j == 0) ? a + 1 : a + 3 + PERIOD * (j - 1);
      check({tag, "_ptr_read_cycle"}, 32'(rd_cycs[base_rd + j] - a), 32'(exp_c - a));
    end
    m_slave_prod = new_p;
    m_dut_prod   = new_p;
    if (d >= 0) m_slave_cons = new_p;
    if (got) handshake();
    else pulse_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, rc, base_wr, seen;
    bit got;
    logic [1:0] hold0, hold1;

    // Reset state.
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fields", {28'd0, resp_status_0, resp_status_1} | 32'({resp_producer, resp_timeout}), 32'd0);
    check("rst_reg_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_reg_offset", 32'(reg_offset), 32'd0);
    check("rst_reg_wr_data", reg_wr_data, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // STATUS right after reset.
    st0 = 2'b10;
    st1 = 2'b01;
    do_status("status_basic");

    // SUBMIT with producer 0 and consumer echo 5 cycles after the write.
    st0 = 2'b11;
    st1 = 2'b00;
    do_submit(5, "submit_basic");

    // Randomised mix of commands.
    for (int n = 0; n < 10; n++) begin
      st0 = 2'($urandom);
      st1 = 2'($urandom);
      if ($urandom_range(1, 0) == 1) do_status("rand_status");
      else do_submit(int'($urandom_range(13, 2)), "rand_submit");
    end

    // Response back-pressure for 10 cycles with cmd_valid held high.
    st0 = 2'b01;
    st1 = 2'b10;
    hold0 = st0;
    hold1 = st1;
    base_wr = wr_count;
    issue(1'b1, a);
    wait_resp(20, rc, got);
    check("stall_resp_seen", 32'(got), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 1'($urandom);
    st0 = ~hold0;
    st1 = ~hold1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_status_0", 32'(resp_status_0), 32'(hold0));
      check("stall_status_1", 32'(resp_status_1), 32'(hold1));
    end
    cmd_valid = 1'b0;
    handshake();
    @(negedge clk);
    check("stall_after_resp_valid", 32'(resp_valid), 32'd0);
    check("stall_after_cmd_ready", 32'(cmd_ready), 32'd1);
    check("stall_no_write", 32'(wr_count - base_wr), 32'd0);
    st0 = hold0;
    st1 = hold1;

    // Reset while polling: abort, no further writes, no response.
    sync_slave();
    echo_delay = -1;
    base_wr = wr_count;
    issue(1'b0, a);
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_poll_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_poll_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_poll_resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    m_slave_prod = ~m_slave_prod;
    m_dut_prod   = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || !cmd_ready) seen++;
    end
    check("rst_poll_idle_after", 32'(seen), 32'd0);
    check("rst_poll_write_count", 32'(wr_count - base_wr), 32'd1);

    // Consumer never matches.
    sync_slave();
    if (TIMEOUT_EN) begin
      st0 = 2'($urandom);
      st1 = 2'($urandom);
      do_submit(-1, "timeout");
    end else begin
      echo_delay = -1;
      base_wr = wr_count;
      issue(1'b0, a);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("no_timeout_resp", 32'(seen), 32'd0);
      check("no_timeout_one_write", 32'(wr_count - base_wr), 32'd1);
      check("no_timeout_busy", 32'(cmd_ready), 32'd0);
      pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
